// File: rtl/irq_vector_arbiter.sv
// irq_vector_arbiter
//
// Sits between the interrupt controller's pending register and the CPU core.
// It picks one pending source (fixed or round-robin priority), presents its
// index to the CPU with a valid/ready claim, waits for end-of-interrupt, then
// pulses a one-hot acknowledge back to the controller. After the acknowledge
// it waits out a short hold-off, so a pending bit that has not yet been
// cleared is not granted a second time.
//
// Parameters:
//   INTR_WIDTH     - number of interrupt sources (>= 2)
//   IDX_WIDTH      - width of the vector index
//   ROUND_ROBIN    - 1: round-robin priority, 0: fixed priority (lowest index wins)
//   HOLDOFF_CYCLES - idle cycles after the ack before re-arbitration (1..15)
//
// Ports:
//   clk            - rising-edge clock
//   reset_n        - asynchronous active-low reset
//   intr_pending   - pending vector from the interrupt controller
//   cpu_irq_valid  - a vector is being presented to the CPU
//   cpu_irq_vector - granted source index, stable while presented
//   cpu_irq_ready  - CPU claims the presented vector
//   cpu_eoi        - single-cycle end-of-interrupt pulse from the CPU
//   intr_ack       - one-hot acknowledge pulse to the interrupt controller
//   in_service     - a claimed interrupt is being serviced
//   spurious_count - saturating count of grants withdrawn before claim
//
// Every output is a flop. Next values are built from the next state, so no
// input reaches an output without passing through a register.

module irq_vector_arbiter #(
  parameter int INTR_WIDTH     = 8,
  parameter int IDX_WIDTH      = $clog2(INTR_WIDTH),
  parameter int ROUND_ROBIN    = 1,
  parameter int HOLDOFF_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [INTR_WIDTH-1:0] intr_pending,
  output logic                  cpu_irq_valid,
  output logic [IDX_WIDTH-1:0]  cpu_irq_vector,
  input  logic                  cpu_irq_ready,
  input  logic                  cpu_eoi,
  output logic [INTR_WIDTH-1:0] intr_ack,
  output logic                  in_service,
  output logic [7:0]            spurious_count
);

  // The candidate sum needs one extra bit so base + offset can exceed the
  // last index before it is wrapped back into range.
  localparam int                 SUM_WIDTH = IDX_WIDTH + 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(INTR_WIDTH - 1);
  localparam logic [3:0]         HOLD_LOAD = 4'(HOLDOFF_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRESENT = 3'd1,
    SERVICE = 3'd2,
    ACK     = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  state_t                  state, state_next;
  logic [IDX_WIDTH-1:0]    rr_ptr, rr_next;
  logic [IDX_WIDTH-1:0]    vector_next;
  logic [3:0]              hold_cnt, hold_next;
  logic [7:0]              spur_next;
  logic                    valid_next;
  logic                    service_next;
  logic [INTR_WIDTH-1:0]   ack_next;

  logic [IDX_WIDTH-1:0]    base;
  logic [SUM_WIDTH-1:0]    cand_sum;
  logic [IDX_WIDTH-1:0]    cand;
  logic [IDX_WIDTH-1:0]    winner;
  logic                    found;

  // Winner search. Walks every source starting at the base index (rr_ptr in
  // round-robin mode, 0 in fixed mode), wrapping past the last source, and
  // keeps the first pending one. The explicit wrap also works for widths
  // that are not a power of two.
  always_comb begin
    base     = (ROUND_ROBIN != 0) ? rr_ptr : '0;
    winner   = '0;
    found    = 1'b0;
    cand_sum = '0;
    cand     = '0;
    for (int i = 0; i < INTR_WIDTH; i++) begin
      cand_sum = {1'b0, base} + SUM_WIDTH'(i);
      if (cand_sum >= SUM_WIDTH'(INTR_WIDTH)) begin
        cand_sum = cand_sum - SUM_WIDTH'(INTR_WIDTH);
      end
      cand = cand_sum[IDX_WIDTH-1:0];
      if (!found && intr_pending[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Next-state logic. A claim takes precedence over a withdrawal seen in the
  // same cycle. The round-robin pointer moves only on a successful claim, so
  // a withdrawn grant leaves the priority order untouched. The registered
  // outputs are derived from the state being entered, which keeps each one
  // aligned with its state.
  always_comb begin
    state_next   = state;
    vector_next  = cpu_irq_vector;
    rr_next      = rr_ptr;
    hold_next    = hold_cnt;
    spur_next    = spurious_count;
    valid_next   = 1'b0;
    service_next = 1'b0;
    ack_next     = '0;

    case (state)
      IDLE: begin
        if (|intr_pending) begin
          state_next  = PRESENT;
          vector_next = winner;
        end
      end
      PRESENT: begin
        if (cpu_irq_ready) begin
          state_next = SERVICE;
          rr_next    = (cpu_irq_vector == LAST_IDX) ? '0 : cpu_irq_vector + 1'b1;
        end else if (!intr_pending[cpu_irq_vector]) begin
          state_next = IDLE;
          if (spurious_count != 8'hFF) begin
            spur_next = spurious_count + 8'd1;
          end
        end
      end
      SERVICE: begin
        if (cpu_eoi) begin
          state_next = ACK;
        end
      end
      ACK: begin
        state_next = HOLDOFF;
        hold_next  = HOLD_LOAD;
      end
      HOLDOFF: begin
        if (hold_cnt == 4'd0) begin
          state_next = IDLE;
        end else begin
          hold_next = hold_cnt - 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    valid_next   = (state_next == PRESENT);
    service_next = (state_next == SERVICE);
    if (state_next == ACK) begin
      ack_next[vector_next] = 1'b1;
    end
  end

  // State and output registers. Reset clears everything immediately,
  // including mid-grant or mid-service, so no acknowledge is ever emitted
  // for an interrupt cut short by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      hold_cnt       <= 4'd0;
      cpu_irq_valid  <= 1'b0;
      cpu_irq_vector <= '0;
      intr_ack       <= '0;
      in_service     <= 1'b0;
      spurious_count <= 8'd0;
    end else begin
      state          <= state_next;
      rr_ptr         <= rr_next;
      hold_cnt       <= hold_next;
      cpu_irq_valid  <= valid_next;
      cpu_irq_vector <= vector_next;
      intr_ack       <= ack_next;
      in_service     <= service_next;
      spurious_count <= spur_next;
    end
  end

endmodule

// File: tb/tb_irq_vector_arbiter.sv
// Testbench for irq_vector_arbiter.
//
// Three instances share clock, reset, ready and eoi; each has its own pending
// input. An instance whose pending input is zero stays idle and ignores the
// shared ready/eoi, so each test phase exercises just one instance:
//   dut_main - round-robin, 8 sources (cycle table, sweep, withdrawals, reset)
//   dut_fx   - fixed priority, 8 sources
//   dut_w6   - round-robin, 6 sources (non-power-of-two wrap)

module tb_irq_vector_arbiter;

  logic       clk;
  logic       reset_n;
  logic       ready;
  logic       eoi;

  logic [7:0] pend_main;
  logic       valid_main;
  logic [2:0] vec_main;
  logic [7:0] ack_main;
  logic       svc_main;
  logic [7:0] spur_main;

  logic [7:0] pend_fx;
  logic       valid_fx;
  logic [2:0] vec_fx;
  logic [7:0] ack_fx;
  logic       svc_fx;
  logic [7:0] spur_fx;

  logic [5:0] pend_w6;
  logic       valid_w6;
  logic [2:0] vec_w6;
  logic [5:0] ack_w6;
  logic       svc_w6;
  logic [7:0] spur_w6;

  int checks;
  int failures;

  irq_vector_arbiter #(.INTR_WIDTH(8), .ROUND_ROBIN(1), .HOLDOFF_CYCLES(2)) dut_main (
    .clk(clk), .reset_n(reset_n), .intr_pending(pend_main),
    .cpu_irq_valid(valid_main), .cpu_irq_vector(vec_main),
    .cpu_irq_ready(ready), .cpu_eoi(eoi), .intr_ack(ack_main),
    .in_service(svc_main), .spurious_count(spur_main)
  );

  irq_vector_arbiter #(.INTR_WIDTH(8), .ROUND_ROBIN(0), .HOLDOFF_CYCLES(2)) dut_fx (
    .clk(clk), .reset_n(reset_n), .intr_pending(pend_fx),
    .cpu_irq_valid(valid_fx), .cpu_irq_vector(vec_fx),
    .cpu_irq_ready(ready), .cpu_eoi(eoi), .intr_ack(ack_fx),
    .in_service(svc_fx), .spurious_count(spur_fx)
  );

  irq_vector_arbiter #(.INTR_WIDTH(6), .ROUND_ROBIN(1), .HOLDOFF_CYCLES(2)) dut_w6 (
    .clk(clk), .reset_n(reset_n), .intr_pending(pend_w6),
    .cpu_irq_valid(valid_w6), .cpu_irq_vector(vec_w6),
    .cpu_irq_ready(ready), .cpu_eoi(eoi), .intr_ack(ack_w6),
    .in_service(svc_w6), .spurious_count(spur_w6)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of the main-instance table: inputs driven before the edge and
  // the expected registered outputs after it.
  typedef struct {
    logic [7:0] pend;
    logic       rdy;
    logic       e;
    logic       exp_valid;
    logic [2:0] exp_vec;
    logic       exp_svc;
    logic [7:0] exp_ack;
    logic [7:0] exp_spur;
  } row_t;

  row_t tbl [27];

  // Compares one value against its expectation and records the result.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drives the main instance's inputs for one table row.
  task automatic applyStimulus(input row_t r);
    pend_main = r.pend;
    ready     = r.rdy;
    eoi       = r.e;
  endtask

  // Returns the outputs of the selected instance (0 main, 1 fixed, 2 six-wide).
  task automatic readDut(input int which, output logic v, output logic [2:0] vec,
                         output logic svc, output logic [7:0] ack,
                         output logic [7:0] spur);
    case (which)
      0: begin v = valid_main; vec = vec_main; svc = svc_main; ack = ack_main; spur = spur_main; end
      1: begin v = valid_fx; vec = vec_fx; svc = svc_fx; ack = ack_fx; spur = spur_fx; end
      default: begin
        v = valid_w6; vec = vec_w6; svc = svc_w6; ack = {2'b00, ack_w6}; spur = spur_w6;
      end
    endcase
  endtask

  // Waits a bounded number of cycles for the selected instance to present.
  task automatic waitValid(input int which, input string tag, output bit ok);
    logic v, svc;
    logic [2:0] vec;
    logic [7:0] ack, spur;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      readDut(which, v, vec, svc, ack, spur);
      if (v) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s timeout: valid never rose, expected valid within 20 cycles", tag);
    end
  endtask

  // Full grant / claim / EOI / ack sequence with the expected vector.
  task automatic serveOne(input int which, input logic [2:0] exp_vec, input string tag);
    bit ok;
    logic v, svc;
    logic [2:0] vec;
    logic [7:0] ack, spur, exp_ack;
    exp_ack = 8'h01 << exp_vec;
    waitValid(which, tag, ok);
    if (ok) begin
      readDut(which, v, vec, svc, ack, spur);
      checkOutput({tag, " vector"}, 32'(vec), 32'(exp_vec));
      ready = 1'b1;
      @(posedge clk); #1;
      ready = 1'b0;
      readDut(which, v, vec, svc, ack, spur);
      checkOutput({tag, " claim valid/svc"}, 32'({v, svc}), 32'(2'b01));
      eoi = 1'b1;
      @(posedge clk); #1;
      eoi = 1'b0;
      readDut(which, v, vec, svc, ack, spur);
      checkOutput({tag, " ack svc/ack"}, 32'({svc, ack}), 32'({1'b0, exp_ack}));
      @(posedge clk); #1;
      readDut(which, v, vec, svc, ack, spur);
      checkOutput({tag, " ack one cycle"}, 32'(ack), 32'h0);
    end
  endtask

  // Holds reset for two edges and releases it away from the clock edge.
  task automatic doReset();
    reset_n = 1'b0;
    ready   = 1'b0;
    eoi     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    bit ok;
    logic v, svc;
    logic [2:0] vec;
    logic [7:0] ack, spur;

    checks    = 0;
    failures  = 0;
    reset_n   = 1'b0;
    ready     = 1'b0;
    eoi       = 1'b0;
    pend_main = 8'h00;
    pend_fx   = 8'h00;
    pend_w6   = 6'h00;

    // Cycle table for the round-robin instance: pend, ready, eoi | valid, vec, svc, ack, spur
    tbl[0]  = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'd0};
    tbl[1]  = '{8'h04, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 8'h00, 8'd0};
    tbl[2]  = '{8'h04, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 8'h00, 8'd0};
    tbl[3]  = '{8'h04, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 8'h00, 8'd0};
    tbl[4]  = '{8'h04, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 8'h00, 8'd0};
    tbl[5]  = '{8'h04, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 8'h04, 8'd0};
    tbl[6]  = '{8'h04, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 8'h00, 8'd0};
    tbl[7]  = '{8'h04, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 8'h00, 8'd0};
    tbl[8]  = '{8'h04, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 8'h00, 8'd0};
    tbl[9]  = '{8'h04, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 8'h00, 8'd0};
    tbl[10] = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 8'h00, 8'd1};
    tbl[11] = '{8'h08, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 8'h00, 8'd1};
    tbl[12] = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 8'h00, 8'd1};
    tbl[13] = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 8'h00, 8'd1};
    tbl[14] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 8'h08, 8'd1};
    tbl[15] = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 8'h00, 8'd1};
    tbl[16] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 8'h00, 8'd1};
    tbl[17] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 8'h00, 8'd1};
    tbl[18] = '{8'h00, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 8'h00, 8'd1};
    tbl[19] = '{8'h28, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 8'h00, 8'd1};
    tbl[20] = '{8'h08, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 8'h00, 8'd2};
    tbl[21] = '{8'h08, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 8'h00, 8'd2};
    tbl[22] = '{8'h08, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 8'h00, 8'd2};
    tbl[23] = '{8'h08, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 8'h08, 8'd2};
    tbl[24] = '{8'h08, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 8'h00, 8'd2};
    tbl[25] = '{8'h08, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 8'h00, 8'd2};
    tbl[26] = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 8'h00, 8'd2};

    $display("[TB] reset state");
    repeat (2) @(posedge clk);
    #1;
    readDut(0, v, vec, svc, ack, spur);
    checkOutput("reset outputs", 32'({v, vec, svc, ack, spur}), 32'h0);
    reset_n = 1'b1;

    $display("[TB] cycle table on round-robin instance");
    for (int i = 0; i < 27; i++) begin
      applyStimulus(tbl[i]);
      @(posedge clk);
      #1;
      readDut(0, v, vec, svc, ack, spur);
      checkOutput($sformatf("row%0d {valid,vec,svc,ack,spur}", i),
                  32'({v, vec, svc, ack, spur}),
                  32'({tbl[i].exp_valid, tbl[i].exp_vec, tbl[i].exp_svc,
                       tbl[i].exp_ack, tbl[i].exp_spur}));
    end

    $display("[TB] round-robin sweep, 8 sources");
    doReset();
    pend_main = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      serveOne(0, 3'(k % 8), $sformatf("rr8 grant%0d", k));
    end
    pend_main = 8'h00;

    $display("[TB] round-robin sweep, 6 sources");
    pend_w6 = 6'h3F;
    for (int k = 0; k < 7; k++) begin
      serveOne(2, 3'(k % 6), $sformatf("rr6 grant%0d", k));
    end
    pend_w6 = 6'h00;

    $display("[TB] fixed priority");
    pend_fx = 8'hA4;
    waitValid(1, "fx first", ok);
    if (ok) begin
      readDut(1, v, vec, svc, ack, spur);
      checkOutput("fx first vector", 32'(vec), 32'd2);
      @(posedge clk); #1;
      readDut(1, v, vec, svc, ack, spur);
      checkOutput("fx vector stable {valid,vec}", 32'({v, vec}), 32'({1'b1, 3'd2}));
      ready = 1'b1;
      @(posedge clk); #1;
      ready = 1'b0;
      repeat (2) begin
        @(posedge clk); #1;
      end
      readDut(1, v, vec, svc, ack, spur);
      checkOutput("fx still in service", 32'({svc, ack}), 32'({1'b1, 8'h00}));
      eoi = 1'b1;
      @(posedge clk); #1;
      eoi = 1'b0;
      pend_fx = 8'hA0;
      readDut(1, v, vec, svc, ack, spur);
      checkOutput("fx ack", 32'(ack), 32'h04);
      @(posedge clk); #1;
      readDut(1, v, vec, svc, ack, spur);
      checkOutput("fx ack one cycle", 32'(ack), 32'h00);
    end
    serveOne(1, 3'd5, "fx second");
    pend_fx = 8'h06;
    serveOne(1, 3'd1, "fx lowest wins");
    pend_fx = 8'h00;

    $display("[TB] spurious count saturation");
    for (int n = 0; n < 260; n++) begin
      pend_main = 8'h01;
      waitValid(0, "sat grant", ok);
      pend_main = 8'h00;
      @(posedge clk); #1;
      if (n == 253) checkOutput("spur at 254", 32'(spur_main), 32'd254);
      if (n == 254) checkOutput("spur at 255", 32'(spur_main), 32'd255);
    end
    readDut(0, v, vec, svc, ack, spur);
    checkOutput("spur saturated {valid,spur}", 32'({v, spur}), 32'({1'b0, 8'd255}));

    $display("[TB] reset mid-service");
    pend_main = 8'h10;
    waitValid(0, "rst grant", ok);
    readDut(0, v, vec, svc, ack, spur);
    checkOutput("rst grant vector", 32'(vec), 32'd4);
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    readDut(0, v, vec, svc, ack, spur);
    checkOutput("rst in service", 32'(svc), 32'd1);
    #3;
    eoi = 1'b1;
    reset_n = 1'b0;
    #1;
    readDut(0, v, vec, svc, ack, spur);
    checkOutput("async reset {valid,vec,svc,ack,spur}", 32'({v, vec, svc, ack, spur}), 32'h0);
    eoi = 1'b0;
    pend_main = 8'h80;
    @(posedge clk); #1;
    readDut(0, v, vec, svc, ack, spur);
    checkOutput("held in reset {valid,svc,ack}", 32'({v, svc, ack}), 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    readDut(0, v, vec, svc, ack, spur);
    checkOutput("grant after release {valid,vec}", 32'({v, vec}), 32'({1'b1, 3'd7}));
    pend_main = 8'h00;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
